width_adapt_pipe: RTL and testbench
===================================

// Module: width_adapt_pipe
// PURPOSE
//   Elastic valid/ready pipeline that carries a word from an IN_W bus to an OUT_W bus.
//   It applies a per-beat conversion mode: zero-extend/truncate, sign-extend/truncate,
//   unsigned saturate or signed saturate.
//   Generalises plain continuous-assign width extension/truncation into a registered,
//   back-pressurable, overflow-reporting block for datapath seams between differently
//   sized units.
// PARAMETERS
//   IN_W    16  input data width (1..64)
//   OUT_W   32  output data width (1..64); may be <, = or > IN_W
//   STAGES  2   register stages (1..4); latency in cycles at full throughput
//   CNT_W   16  width of the overflow event counter
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous assert, active-low reset
//   in_valid   in   1      input beat present
//   in_ready   out  1      block accepts beat this cycle
//   in_data    in   IN_W   input word
//   in_mode    in   2      conversion mode, captured with the beat
//   out_valid  out  1      output beat present
//   out_ready  in   1      sink accepts beat
//   out_data   out  OUT_W  converted word
//   out_ovf    out  1      this beat lost information (truncated or clamped)
//   ovf_clr    in   1      synchronous clear of ovf_count
//   ovf_count  out  CNT_W  saturating count of delivered beats with out_ovf=1
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valids=0, out_valid=0, out_data=0, out_ovf=0,
//     ovf_count=0. in_ready=1 while in reset and after release. Beats in flight are dropped.
//   Handshake:
//     - Transfer occurs when valid&&ready.
//     - Stage k loads when !v[k] || advance[k+1]; the last stage advances on out_ready.
//     - in_ready = stage-0 load condition (combinational from out_ready through the stall chain).
//     - Bubbles collapse; no beat is lost or duplicated.
//     - out_data/out_ovf hold stable while out_valid && !out_ready.
//   Latency: STAGES cycles from input transfer to out_valid. Throughput is 1 beat/cycle
//     with out_ready=1.
//   Conversion happens in stage 0. in_mode travels only implicitly, so mode changes
//     affect only new beats.
//   Modes with OUT_W >= IN_W:
//     - Modes 0 and 2 zero-extend; modes 1 and 3 sign-extend from in_data[IN_W-1].
//     - out_ovf=0.
//   Modes with OUT_W < IN_W (D = discarded bits [IN_W-1:OUT_W]):
//     - 0 ZTRUNC: keep low OUT_W bits; ovf = |D.
//     - 1 STRUNC: keep low OUT_W bits; ovf = D not all equal to in_data[OUT_W-1].
//     - 2 USAT: if |D, out = all-ones, ovf=1; else low bits.
//     - 3 SSAT: out = signed max (0111..) or signed min (1000..) when the value is out of
//       range, ovf=1; else low bits.
//   ovf_count:
//     - Increments on each output transfer with out_ovf=1.
//     - Sticks at 2^CNT_W-1.
//     - ovf_clr alone clears to 0. ovf_clr coincident with an increment gives 1.
//   Simultaneous in and out transfer with a full pipe: both proceed in the same cycle,
//     and occupancy is unchanged.
// STRUCTURE
//   Package width_adapt_pkg holds:
//     - mode localparams MODE_ZTRUNC=0, MODE_STRUNC=1, MODE_USAT=2, MODE_SSAT=3;
//     - function conv(in, mode) returning {ovf, data}.
//   Sub-module width_adapt_stage (parametrised payload width, one elastic register
//   slot: v, data, load/advance logic) is instantiated STAGES times in a generate loop.
//   Top-level contains the conversion, the stage chain and the counter.
// TESTING (IN_W=16, OUT_W=32 unless noted; STAGES=2)
//   1. 0x0000 then 0xFFFF in mode 0 -> 0x00000000, 0x0000FFFF. Both appear 2 cycles after
//      their accept; ovf=0.
//   2. 0xFFFF mode 1 -> 0xFFFFFFFF. 0x7FFF mode 3 -> 0x00007FFF; ovf=0.
//   3. IN_W=16, OUT_W=8:
//      - 0x01FF mode 0 -> 0xFF, ovf=1; mode 2 -> 0xFF, ovf=1.
//      - 0xFF80 mode 1 -> 0x80, ovf=0.
//      - 0x0180 mode 3 -> 0x7F, ovf=1; 0xFE00 mode 3 -> 0x80, ovf=1.
//      - ovf_count = 4.
//   4. Stream 8 beats 1..8 with out_ready low on cycles 3-5:
//      - in_ready drops once 2 beats are held;
//      - output order is 1..8, no gaps beyond the stall;
//      - out_data is stable while stalled.
//   5. Assert rst_n low with 2 beats in flight:
//      - out_valid=0 and ovf_count=0 immediately (asynchronous);
//      - after release the first new beat emerges with latency 2.
//   6. ovf_clr pulsed in the same cycle as an ovf beat transfer -> ovf_count=1.
//      Force CNT_W=2 with 5 ovf beats -> ovf_count holds at 3.

Source files
------------

// File: rtl/width_adapt_pkg.sv
// rtl/width_adapt_pkg.sv - conversion modes and the width conversion function
package width_adapt_pkg;

  localparam logic [1:0] MODE_ZTRUNC = 2'd0;
  localparam logic [1:0] MODE_STRUNC = 2'd1;
  localparam logic [1:0] MODE_USAT   = 2'd2;
  localparam logic [1:0] MODE_SSAT   = 2'd3;

  // Returns {ovf, data}; din is zero-padded to 64 bits, only the low out_w result bits matter.
  function automatic logic [64:0] conv(input logic [63:0] din, input logic [1:0] mode,
                                       input int in_w, input int out_w);
    logic [63:0] res;
    logic        ovf;
    logic        sgn;
    logic        top;
    logic        any_d;
    logic        mixed_d;
    res     = '0;
    ovf     = 1'b0;
    sgn     = 1'b0;
    top     = 1'b0;
    any_d   = 1'b0;
    mixed_d = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == in_w - 1)  sgn = din[i];
      if (i == out_w - 1) top = din[i];
    end
    for (int i = 0; i < 64; i++) begin
      if (i < in_w && i < out_w) res[i] = din[i];
      else if (i < out_w)        res[i] = mode[0] & sgn;
      if (i >= out_w && i < in_w) begin
        any_d   = any_d | din[i];
        mixed_d = mixed_d | (din[i] ^ top);
      end
    end
    // Signed range check: bits [in_w-1:out_w-1] must all agree for the value to fit.
    if (out_w < in_w) begin
      case (mode)
        MODE_ZTRUNC: ovf = any_d;
        MODE_STRUNC: ovf = mixed_d;
        MODE_USAT: begin
          if (any_d) begin
            ovf = 1'b1;
            for (int i = 0; i < 64; i++) begin
              if (i < out_w) res[i] = 1'b1;
            end
          end
        end
        default: begin
          if (mixed_d) begin
            ovf = 1'b1;
            for (int i = 0; i < 64; i++) begin
              if (i < out_w) res[i] = (i == out_w - 1) ? sgn : !sgn;
            end
          end
        end
      endcase
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/width_adapt_stage.sv
// rtl/width_adapt_stage.sv - one elastic register slot of the adapter pipeline
module width_adapt_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         v;
  logic [W-1:0] data;
  logic         load;

  // Slot refills when empty or when its occupant leaves this cycle.
  assign load      = !v || out_ready;
  assign out_valid = v;
  assign out_data  = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      data <= '0;
    end else if (load) begin
      v <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/width_adapt_pipe.sv
// rtl/width_adapt_pipe.sv - registered, back-pressurable width adapter with overflow count
module width_adapt_pipe
  import width_adapt_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PW = OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [63:0]   in_ext;
  logic [64:0]   cv;
  logic          conv_unused;
  logic [PW-1:0] pay [STAGES+1];
  logic          vld [STAGES+1];
  logic [STAGES:0] rdy;
  logic          ovf_xfer;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    in_ext = '0;
    in_ext[IN_W-1:0] = in_data;
  end

  assign cv          = conv(in_ext, in_mode, IN_W, OUT_W);
  assign conv_unused = ^cv;
  assign pay[0]      = {cv[64], cv[OUT_W-1:0]};
  assign vld[0]      = in_valid;

  // Ready chain resolved back-to-front in one block so the stall propagates in a single cycle.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld[k+1] || rdy[k+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    width_adapt_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[g]),
      .in_data   (pay[g]),
      .out_ready (rdy[g+1]),
      .out_valid (vld[g+1]),
      .out_data  (pay[g+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign out_data  = pay[STAGES][OUT_W-1:0];
  assign out_ovf   = pay[STAGES][OUT_W];

  assign ovf_xfer  = out_valid && out_ready && out_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ovf_clr) begin
      cnt <= ovf_xfer ? CNT_W'(1) : '0;
    end else if (ovf_xfer && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ovf_count = cnt;

endmodule

// File: tb/tb_width_adapt_pipe.sv
// tb/tb_width_adapt_pipe.sv - self-checking bench for width_adapt_pipe
module tb_width_adapt_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [3];
  logic        in_ready [3];
  logic [15:0] in_data [3];
  logic [1:0]  in_mode [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        out_ovf [3];
  logic        ovf_clr [3];
  logic [31:0] od [3];
  logic [15:0] oc [3];
  logic [7:0]  od_b, od_c;
  logic [1:0]  oc_c;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [32:0] exp_q [3][$];
  int          exp_cnt [3];
  logic        hold_v [3];
  logic [31:0] hold_d [3];
  logic        hold_o [3];

  assign od[1] = {24'h0, od_b};
  assign od[2] = {24'h0, od_c};
  assign oc[2] = {14'h0, oc_c};

  always #5 clk = ~clk;

  width_adapt_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od[0]), .out_ovf(out_ovf[0]),
    .ovf_clr(ovf_clr[0]), .ovf_count(oc[0]));

  width_adapt_pipe #(.IN_W(16), .OUT_W(8), .STAGES(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od_b), .out_ovf(out_ovf[1]),
    .ovf_clr(ovf_clr[1]), .ovf_count(oc[1]));

  width_adapt_pipe #(.IN_W(16), .OUT_W(8), .STAGES(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od_c), .out_ovf(out_ovf[2]),
    .ovf_clr(ovf_clr[2]), .ovf_count(oc_c));

  function automatic int out_w(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic int cnt_max(int d);
    return (d == 2) ? 3 : 65535;
  endfunction

  // Reference conversion on integer values: {ovf, data}
  function automatic logic [32:0] ref_conv(int w, logic [15:0] din, logic [1:0] m);
    longint u, s, umax, smax, smin, r;
    logic   o;
    u    = longint'(din);
    s    = longint'($signed(din));
    umax = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -smax - 1;
    o    = 1'b0;
    r    = u;
    if (w >= 16) begin
      r = m[0] ? s : u;
    end else begin
      case (m)
        2'd0: begin r = u; o = (u > umax); end
        2'd1: begin r = u; o = (s > smax) || (s < smin); end
        2'd2: begin
          if (u > umax) begin r = umax; o = 1'b1; end
          else r = u;
        end
        default: begin
          if (s > smax)      begin r = smax; o = 1'b1; end
          else if (s < smin) begin r = smin; o = 1'b1; end
          else r = s;
        end
      endcase
    end
    r = r & umax;
    return {o, r[31:0]};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples handshakes at the falling edge, updates the model, then advances one cycle.
  task automatic tick();
    logic [32:0] e;
    logic        inc;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (hold_v[d]) begin
        check($sformatf("hold_valid[%0d]", d), out_valid[d], 1);
        check($sformatf("hold_data[%0d]", d), od[d], hold_d[d]);
        check($sformatf("hold_ovf[%0d]", d), out_ovf[d], hold_o[d]);
      end
      hold_v[d] = out_valid[d] && !out_ready[d];
      hold_d[d] = od[d];
      hold_o[d] = out_ovf[d];
      check($sformatf("ovf_count[%0d]", d), oc[d], exp_cnt[d]);
      inc = 1'b0;
      if (out_valid[d] && out_ready[d]) begin
        if (exp_q[d].size() == 0) begin
          check($sformatf("spurious_out[%0d]", d), 1, 0);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("out_data[%0d]", d), od[d], e[31:0]);
          check($sformatf("out_ovf[%0d]", d), out_ovf[d], e[32]);
          inc = e[32];
        end
      end
      if (in_valid[d] && in_ready[d])
        exp_q[d].push_back(ref_conv(out_w(d), in_data[d], in_mode[d]));
      if (ovf_clr[d])                         exp_cnt[d] = inc ? 1 : 0;
      else if (inc && exp_cnt[d] < cnt_max(d)) exp_cnt[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One beat into an empty pipe; checks latency 2 and the converted value.
  task automatic send_check(int d, logic [15:0] data, logic [1:0] m,
                            logic [31:0] ed, logic eo, logic clr);
    in_valid[d] = 1'b1; in_data[d] = data; in_mode[d] = m; out_ready[d] = 1'b1;
    #1;
    check($sformatf("accept[%0d]", d), in_ready[d], 1);
    tick();
    in_valid[d] = 1'b0;
    check($sformatf("lat1_valid[%0d]", d), out_valid[d], 0);
    tick();
    check($sformatf("lat2_valid[%0d]", d), out_valid[d], 1);
    check($sformatf("lat2_data[%0d]", d), od[d], ed);
    check($sformatf("lat2_ovf[%0d]", d), out_ovf[d], eo);
    ovf_clr[d] = clr;
    tick();
    ovf_clr[d] = 1'b0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      exp_cnt[d] = 0;
      hold_v[d] = 1'b0;
    end
  endtask

  initial begin
    int   sent;
    logic acc;
    logic [15:0] r;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_mode[d] = '0;
      out_ready[d] = 1'b1; ovf_clr[d] = 1'b0;
    end
    clear_model();
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_valid[%0d]", d), out_valid[d], 0);
      check($sformatf("rst_out_data[%0d]", d), od[d], 0);
      check($sformatf("rst_out_ovf[%0d]", d), out_ovf[d], 0);
      check($sformatf("rst_count[%0d]", d), oc[d], 0);
      check($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1);
    end
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_check(0, 16'h0000, 2'd0, 32'h0000_0000, 1'b0, 1'b0);
    send_check(0, 16'hFFFF, 2'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    send_check(0, 16'hFFFF, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_check(0, 16'h7FFF, 2'd3, 32'h0000_7FFF, 1'b0, 1'b0);

    send_check(1, 16'h01FF, 2'd0, 32'hFF, 1'b1, 1'b0);
    send_check(1, 16'h01FF, 2'd2, 32'hFF, 1'b1, 1'b0);
    send_check(1, 16'hFF80, 2'd1, 32'h80, 1'b0, 1'b0);
    send_check(1, 16'h0180, 2'd3, 32'h7F, 1'b1, 1'b0);
    send_check(1, 16'hFE00, 2'd3, 32'h80, 1'b1, 1'b0);
    check("narrow_count", oc[1], 4);

    ovf_clr[1] = 1'b1;
    tick();
    ovf_clr[1] = 1'b0;
    check("clr_alone", oc[1], 0);
    send_check(1, 16'h01FF, 2'd0, 32'hFF, 1'b1, 1'b0);
    send_check(1, 16'h01FF, 2'd0, 32'hFF, 1'b1, 1'b1);
    check("clr_with_inc", oc[1], 1);

    for (int i = 0; i < 5; i++) send_check(2, 16'h01FF, 2'd2, 32'hFF, 1'b1, 1'b0);
    check("sat_count", oc[2], 3);

    sent = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready[0] = !(c >= 3 && c <= 5);
      in_valid[0]  = (sent < 8);
      in_data[0]   = 16'(sent + 1);
      in_mode[0]   = 2'd0;
      #1;
      if (sent < 8) check($sformatf("stall_in_ready_c%0d", c), in_ready[0], (c >= 3 && c <= 5) ? 0 : 1);
      if (c >= 2 && c <= 12) check($sformatf("stall_out_valid_c%0d", c), out_valid[0], 1);
      acc = in_valid[0] && in_ready[0];
      tick();
      if (acc) sent++;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    check("stall_sent", sent, 8);
    check("stall_drained", exp_q[0].size(), 0);

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 1) == 1) r = {{8{r[7]}}, r[7:0]};
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        in_data[d]   = r;
        in_mode[d]   = 2'($urandom_range(0, 3));
        out_ready[d] = ($urandom_range(0, 2) != 0);
        ovf_clr[d]   = ($urandom_range(0, 31) == 0);
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; ovf_clr[d] = 1'b0;
    end
    for (int c = 0; c < 6; c++) tick();
    for (int d = 0; d < 3; d++) check($sformatf("rand_drained[%0d]", d), exp_q[d].size(), 0);

    in_valid[0] = 1'b1; in_data[0] = 16'h1234; in_mode[0] = 2'd0; out_ready[0] = 1'b0;
    tick();
    in_data[0] = 16'h5678;
    tick();
    in_valid[0] = 1'b0;
    check("inflight_valid", out_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("async_out_valid[%0d]", d), out_valid[d], 0);
      check($sformatf("async_count[%0d]", d), oc[d], 0);
      check($sformatf("async_in_ready[%0d]", d), in_ready[d], 1);
    end
    clear_model();
    out_ready[0] = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_check(0, 16'h00AB, 2'd1, 32'h0000_00AB, 1'b0, 1'b0);
    send_check(0, 16'h8001, 2'd1, 32'hFFFF_8001, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
